// File: rtl/cpu_clk_gen.sv
// cpu_clk_gen: programmable CPU clock derived from the 100 MHz board clock.
// Modes: halt, free run, single step, N-period burst. Each cpu_clk period is
// exactly H low cycles followed by H high cycles, H = max(div_half, 1).
// Optional retired-cycle counter: define CPU_CLK_GEN_COUNTER_EN to build it;
// otherwise cycle_count is tied to 0.
module cpu_clk_gen #(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_100MHz,
  input  logic                   rst,
  input  logic [DIV_WIDTH-1:0]   div_half,
  input  logic [1:0]             mode,
  input  logic                   step_req,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   cpu_clk,
  output logic                   cpu_clk_en,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_BURST} state_e;

  localparam logic [1:0] M_HALT  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  state_e                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   hc_q, hc_d;      // position within the current half
  logic [DIV_WIDTH-1:0]   h_q, h_d;        // half-period latched at period start
  logic [BURST_WIDTH-1:0] rem_q, rem_d;    // burst periods still to run
  logic                   clk_q, clk_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   step_prev_q;
  logic                   step_edge;
  logic                   fin;
  logic [DIV_WIDTH-1:0]   h_new;

  assign step_edge = step_req & ~step_prev_q;
  assign h_new     = (div_half == '0) ? DIV_WIDTH'(1) : div_half;

  // Next-state: start decisions in IDLE, period shaping and end-of-period policy otherwise
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    h_d     = h_q;
    rem_d   = rem_q;
    clk_d   = clk_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    if (state_q == S_IDLE) begin
      clk_d  = 1'b0;
      busy_d = 1'b0;
      hc_d   = '0;
      if (mode == M_RUN) begin
        state_d = S_RUN;
        h_d     = h_new;
        busy_d  = 1'b1;
      end else if (mode == M_STEP && step_edge) begin
        state_d = S_STEP;
        h_d     = h_new;
        busy_d  = 1'b1;
      end else if (mode == M_BURST && step_edge) begin
        // A zero-length burst completes without ever leaving IDLE
        if (burst_len == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = S_BURST;
          h_d     = h_new;
          rem_d   = burst_len;
          busy_d  = 1'b1;
        end
      end
    end else if (hc_q != h_q - DIV_WIDTH'(1)) begin
      hc_d = hc_q + DIV_WIDTH'(1);
    end else begin
      hc_d = '0;
      if (!clk_q) begin
        clk_d = 1'b1;
        en_d  = 1'b1;
      end else begin
        // Falling edge: the only point where the mode is re-examined
        clk_d = 1'b0;
        case (state_q)
          S_RUN:   fin = (mode != M_RUN);
          S_STEP:  fin = 1'b1;
          default: begin
            rem_d = rem_q - BURST_WIDTH'(1);
            fin   = (rem_q == BURST_WIDTH'(1)) || (mode == M_HALT);
          end
        endcase
        done_d = fin && (state_q != S_RUN);
        if (fin) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          h_d = h_new;
        end
      end
    end
  end

  // State and registered outputs; reset forces cpu_clk low immediately
  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hc_q        <= '0;
      h_q         <= DIV_WIDTH'(1);
      rem_q       <= '0;
      clk_q       <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      h_q         <= h_d;
      rem_q       <= rem_d;
      clk_q       <= clk_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_prev_q <= step_req;
    end
  end

  assign cpu_clk    = clk_q;
  assign cpu_clk_en = en_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef CPU_CLK_GEN_COUNTER_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Count cpu_clk rising edges; the count moves together with cpu_clk_en
  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (en_d) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: randomized runs, steps, bursts, aborts and resets
// compared cycle by cycle against a window model of the cpu_clk waveform.
module tb_cpu_clk_gen;
  localparam int DW = 8;
  localparam int BW = 16;
  localparam int CW = 32;

  logic          clk_100MHz = 1'b0;
  logic          rst;
  logic [DW-1:0] div_half  = '0;
  logic [1:0]    mode      = 2'b00;
  logic          step_req  = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          cpu_clk, cpu_clk_en, busy, done;
  logic [CW-1:0] cycle_count;

  int     total = 0;
  int     bad   = 0;
  longint model_rises = 0;

  cpu_clk_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .div_half   (div_half),
    .mode       (mode),
    .step_req   (step_req),
    .burst_len  (burst_len),
    .cpu_clk    (cpu_clk),
    .cpu_clk_en (cpu_clk_en),
    .busy       (busy),
    .done       (done),
    .cycle_count(cycle_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Expected {cpu_clk, cpu_clk_en, busy, done} in cycle j after a start in
  // cycle 0: n periods of h low + h high cycles, then a done pulse if fin.
  function automatic logic [3:0] exp_sig(int j, int h, int n, bit fin);
    int tot, p;
    logic [3:0] r;
    r   = '0;
    tot = 2 * h * n;
    if (j >= 1 && j <= tot) begin
      p    = (j - 1) % (2 * h);
      r[3] = (p >= h);
      r[2] = (p == h);
      r[1] = 1'b1;
    end else if (fin && j == tot + 1) begin
      r[0] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef CPU_CLK_GEN_COUNTER_EN
    return CW'(model_rises);
`else
    return '0;
`endif
  endfunction

  task automatic idle(int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100MHz);
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== 4'b0 || cycle_count !== '0) begin
        bad++;
        $display("FAIL reset_hold i=%0d got=%b/%0d want=0000/0", i,
                 {cpu_clk, cpu_clk_en, busy, done}, cycle_count);
      end
    end
    rst  = 1'b1;
    mode = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_100MHz);
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== 4'b0 || cycle_count !== '0) begin
        bad++;
        $display("FAIL halt_idle i=%0d got=%b/%0d want=0000/0", i,
                 {cpu_clk, cpu_clk_en, busy, done}, cycle_count);
      end
    end
  endtask

  // Free run of n periods; mode drops to halt somewhere in the last period.
  task automatic test_run(int dv, int n, bit rnd_stop);
    int h, stop_j;
    logic [3:0] e;
    h      = (dv == 0) ? 1 : dv;
    stop_j = rnd_stop ? 2*h*(n-1) + int'($urandom_range(1, 2*h)) : 2*h*n;
    div_half = DW'(dv);
    mode     = 2'b01;
    for (int j = 1; j <= 2*h*n + 4; j++) begin
      @(negedge clk_100MHz);
      e = exp_sig(j, h, n, 1'b0);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL run h=%0d j=%0d got=%b want=%b", h, j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
      if (j == stop_j) mode = 2'b00;
    end
    total++;
    if (cycle_count !== exp_cnt()) begin
      bad++;
      $display("FAIL run_count got=%0d want=%0d", cycle_count, exp_cnt());
    end
  endtask

  // div_half 0 -> 2-cycle periods; switch to 3 mid-period of period k.
  task automatic test_div_change(int k);
    int b;
    logic [3:0] e;
    b        = 2*k + 2;
    div_half = '0;
    mode     = 2'b01;
    for (int j = 1; j <= b + 15; j++) begin
      @(negedge clk_100MHz);
      e = (j <= b) ? exp_sig(j, 1, k + 1, 1'b0) : exp_sig(j - b, 3, 2, 1'b0);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL div_change j=%0d got=%b want=%b", j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
      if (j == 2*k + 1) div_half = 8'd3;
      if (j == b + 12)  mode = 2'b00;
    end
  endtask

  // Two single-cycle step pulses 40 cycles apart, then step_req held high.
  task automatic test_step();
    int h, dones;
    logic [3:0] e;
    div_half = 8'd4;
    mode     = 2'b10;
    step_req = 1'b1;
    dones    = 0;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk_100MHz);
      e = exp_sig(j, 4, 1, 1'b1) | exp_sig(j - 40, 4, 1, 1'b1);
      if (e[2]) model_rises++;
      if (done) dones++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL step j=%0d got=%b want=%b", j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
      step_req = (j == 40);
    end
    total++;
    if (dones !== 2) begin
      bad++;
      $display("FAIL step_dones got=%0d want=2", dones);
    end
    h        = int'($urandom_range(1, 6));
    div_half = DW'(h);
    step_req = 1'b1;
    for (int j = 1; j <= 2*h + 40; j++) begin
      @(negedge clk_100MHz);
      e = exp_sig(j, h, 1, 1'b1);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL step_hold h=%0d j=%0d got=%b want=%b", h, j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
    end
    step_req = 1'b0;
    mode     = 2'b00;
  endtask

  task automatic test_burst(int dv, int n);
    int h;
    logic [3:0] e;
    h         = (dv == 0) ? 1 : dv;
    div_half  = DW'(dv);
    burst_len = BW'(n);
    mode      = 2'b11;
    step_req  = 1'b1;
    for (int j = 1; j <= 2*h*n + 4; j++) begin
      @(negedge clk_100MHz);
      step_req = 1'b0;
      e = exp_sig(j, h, n, 1'b1);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL burst h=%0d n=%0d j=%0d got=%b want=%b", h, n, j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
    end
    total++;
    if (cycle_count !== exp_cnt()) begin
      bad++;
      $display("FAIL burst_count got=%0d want=%0d", cycle_count, exp_cnt());
    end
    mode = 2'b00;
  endtask

  // Burst of 100 aborted by halt during period p: period p still completes.
  task automatic test_abort(int h, int p);
    int abort_j;
    logic [3:0] e;
    abort_j   = 2*h*p + int'($urandom_range(1, 2*h));
    div_half  = DW'(h);
    burst_len = 16'd100;
    mode      = 2'b11;
    step_req  = 1'b1;
    for (int j = 1; j <= 2*h*(p+1) + 4; j++) begin
      @(negedge clk_100MHz);
      step_req = 1'b0;
      e = exp_sig(j, h, p + 1, 1'b1);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL abort h=%0d j=%0d got=%b want=%b", h, j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
      if (j == abort_j) mode = 2'b00;
    end
  endtask

  // Reset asserted right after the third rise of a 100-period burst.
  task automatic test_reset_mid(int h);
    logic [3:0] e;
    div_half  = DW'(h);
    burst_len = 16'd100;
    mode      = 2'b11;
    step_req  = 1'b1;
    for (int j = 1; j <= 5*h + 1; j++) begin
      @(negedge clk_100MHz);
      step_req = 1'b0;
      e = exp_sig(j, h, 100, 1'b1);
      if (e[2]) model_rises++;
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== e) begin
        bad++;
        $display("FAIL rst_mid_pre j=%0d got=%b want=%b", j, {cpu_clk, cpu_clk_en, busy, done}, e);
      end
    end
    #1 rst = 1'b0;
    model_rises = 0;
    #1;
    total++;
    if ({cpu_clk, busy, done} !== 3'b0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL rst_mid_async got=%b/%0d want=000/0", {cpu_clk, busy, done}, cycle_count);
    end
    mode = 2'b00;
    idle(2);
    rst = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_100MHz);
      total++;
      if ({cpu_clk, cpu_clk_en, busy, done} !== 4'b0 || cycle_count !== '0) begin
        bad++;
        $display("FAIL rst_mid_after j=%0d got=%b/%0d want=0000/0", j,
                 {cpu_clk, cpu_clk_en, busy, done}, cycle_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    test_reset();
    test_run(32, 4, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      test_run(int'($urandom_range(0, 9)), int'($urandom_range(1, 4)), 1'b1);
      idle(int'($urandom_range(1, 4)));
    end
    test_div_change(int'($urandom_range(1, 4)));
    idle(3);
    test_step();
    idle(3);
    test_burst(2, 5);
    idle(2);
    test_burst(2, 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      test_burst(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
      idle(int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 3; i++) begin
      test_abort(int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));
      idle(2);
    end
    test_reset_mid(int'($urandom_range(1, 6)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_clk_gen.md
Name: cpu_clk_gen

Overview:
- Synthesisable successor to the bench-only CPU clock stimulus.
- Derives the CPU clock from the 100 MHz board clock with a run-time programmable divide ratio.
- Adds halt, single-step and N-cycle burst modes, so the R/I-type CPU core can be run free, stepped or bursted on the board.
- Sits between the board clock pins and the CPU top level, which consumes cpu_clk.

Parameters:
- DIV_WIDTH, 8, width of the half-period count.
- BURST_WIDTH, 16, width of the burst length.
- CNT_WIDTH, 32, width of the retired-cycle counter.

Ports:
- clk_100MHz  input  1  board clock; the only clock of the block.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- div_half  input  DIV_WIDTH  half-period of cpu_clk in clk_100MHz cycles; 0 is treated as 1.
- mode  input  2  operating mode: 00 halt, 01 run, 10 step, 11 burst.
- step_req  input  1  synchronous to clk_100MHz; rising edge starts a step or a burst.
- burst_len  input  BURST_WIDTH  number of cpu_clk periods per burst.
- cpu_clk  output  1  registered CPU clock.
- cpu_clk_en  output  1  one-cycle pulse in the cycle cpu_clk goes 0->1.
- busy  output  1  high while a period, step or burst is in progress.
- done  output  1  one-cycle pulse when a step or burst completes.
- cycle_count  output  CNT_WIDTH  number of cpu_clk rising edges since reset.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, counters cleared, H = 1.
- H = max(div_half, 1).
  - Latched only when a period starts (from IDLE, or at a falling edge that begins another period); never changes mid-period.
- Period shape:
  - Half-period counter hc runs 0..H-1.
  - When hc==H-1 in the low half: cpu_clk <= 1 and cpu_clk_en pulses that cycle.
  - When hc==H-1 in the high half: cpu_clk <= 0.
  - Every period is therefore exactly H low cycles followed by H high cycles; no glitches or runt pulses.
- step_req edge: accepted in the cycle where step_req=1 and the registered previous value=0. Edges are ignored outside IDLE.
- States:
  - IDLE: cpu_clk=0, busy=0.
    - mode=01 -> RUN.
    - mode=10 and edge -> STEP.
    - mode=11 and edge -> BURST, loading remaining = burst_len.
      - If burst_len=0: stay in IDLE and pulse done the next cycle.
  - RUN: continuous periods. At each falling edge, if mode!=01 -> IDLE (no done pulse); otherwise continue.
  - STEP: exactly one period. Done pulses in the same cycle as the falling edge, then -> IDLE.
  - BURST: decrement remaining at each falling edge. When remaining reaches 0, or mode==00 is seen at a falling edge (abort), done pulses and -> IDLE.
- Latency: first rising edge of cpu_clk occurs H cycles after the accept cycle (STEP/BURST) or after IDLE->RUN.
- busy is high from the cycle after the start/accept until the cycle of the final falling edge, inclusive.
- Mode changes mid-period never truncate a period.
- cycle_count increments on every cpu_clk_en and wraps modulo 2^CNT_WIDTH.
- Reset mid-period: cpu_clk drops to 0 immediately (asynchronously). No done pulse.

Optional Feature:
- Macro: CPU_CLK_GEN_COUNTER_EN.
- Defined: cycle_count is implemented as above.
- Undefined: the counter is not built and cycle_count is tied to 0. All other behaviour is unchanged.

Test Plan:
- rst=0 for 5 cycles, then 1, mode=00 -> cpu_clk=0, busy=0, done=0, cycle_count=0 for 50 cycles.
- mode=01, div_half=32 -> cpu_clk period 64 cycles, 50% duty; first rise 32 cycles after entering RUN; cycle_count=4 after 4 rises.
- div_half=0, mode=01 -> period 2 cycles; change div_half to 3 mid-run -> the new 6-cycle period begins only at the next falling edge.
- mode=10, div_half=4, two step_req pulses 40 cycles apart -> exactly two periods of 8 cycles; done pulses twice, each coincident with a falling edge; holding step_req high produces only one step.
- mode=11, burst_len=5, div_half=2 -> 5 rising edges, done after 20 cycles of activity. With burst_len=0 -> no edges and done one cycle after the accept.
- Burst of 100, assert rst=0 at rise #3 -> cpu_clk=0 immediately, busy=0, no done, cycle_count=0. Separately, mode=00 mid-burst -> the current period completes, then done and IDLE.
